spi_coproc_ctrl: RTL and testbench

//  SPI master controller that serves the EXECUTE stage's coprocessor requests.
//  - Accepts one operation (opcode, two 32-bit operands, 4-bit dest tag).
//  - Selects the ALU, MUL or BAS slave from the opcode and shifts out a 72-bit command frame.
//  - Reads back a 32-bit result and reports it with a done pulse.
//  - Owns the single shared SPI bus; only one transaction is in flight at a time.

---
 rtl/spi_coproc_ctrl.sv | 169 ++++++++++++++++
 tb/tb_spi_coproc_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_coproc_ctrl.sv
// SPI master serving EXECUTE-stage coprocessor ops: 72-bit command out, result back in.
// Define SPI_CHECKSUM_EN to read an extra XOR checksum byte and flag mismatches on err.
module spi_coproc_ctrl #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned TA_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic [2:0]  opcode,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic [3:0]  addrIn,
  output logic [31:0] res,
  output logic [3:0]  addrOut,
  output logic        done,
  output logic        err,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        nssAlu,
  output logic        nssMul,
  output logic        nssBas
);

`ifdef SPI_CHECKSUM_EN
  localparam int unsigned RX_BITS = 40;
`else
  localparam int unsigned RX_BITS = 32;
`endif
  localparam int unsigned HcW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HcW-1:0] HalfLastVal = HcW'(CLK_DIV - 1);
  localparam logic [6:0] TxLast  = 7'd71;
  localparam logic [6:0] RxLast  = 7'(RX_BITS - 1);
  localparam logic [6:0] GapLast = 7'(2 * TA_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StTx, StGap, StRx, StHold, StDone} state_e;

  state_e               state;
  logic [HcW-1:0]       halfCnt;
  logic [6:0]           bitCnt;
  logic [71:0]          txShift;
  logic [RX_BITS-1:0]   rxShift;
  logic [3:0]           addrQ;
  logic [71:0]          frame;
  logic                 halfLast;

  assign frame    = {5'b0, opcode, opa, opb};
  assign halfLast = (halfCnt == HalfLastVal);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= StIdle;
      ready   <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      res     <= '0;
      addrOut <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      nssAlu  <= 1'b1;
      nssMul  <= 1'b1;
      nssBas  <= 1'b1;
      halfCnt <= '0;
      bitCnt  <= '0;
      txShift <= '0;
      rxShift <= '0;
      addrQ   <= '0;
    end else begin
      done <= 1'b0;
      if (state != StIdle) halfCnt <= halfLast ? '0 : halfCnt + 1'b1;
      case (state)
        StIdle: begin
          if (req && ready) begin
            // First bit goes out now so it is stable for a full half-period before sclk rises.
            mosi    <= frame[71];
            txShift <= {frame[70:0], 1'b0};
            addrQ   <= addrIn;
            ready   <= 1'b0;
            halfCnt <= '0;
            nssAlu  <= opcode[2];
            nssMul  <= !(opcode[2] && !opcode[1]);
            nssBas  <= !(opcode[2] && opcode[1]);
            state   <= StSetup;
          end
        end
        StSetup: begin
          if (halfLast) begin
            sclk   <= 1'b1;
            bitCnt <= '0;
            state  <= StTx;
          end
        end
        StTx: begin
          if (halfLast) begin
            if (sclk) begin
              sclk    <= 1'b0;
              mosi    <= (bitCnt == TxLast) ? 1'b0 : txShift[71];
              txShift <= {txShift[70:0], 1'b0};
            end else if (bitCnt == TxLast) begin
              bitCnt <= '0;
              if (TA_CYCLES == 0) begin
                sclk    <= 1'b1;
                rxShift <= {rxShift[RX_BITS-2:0], miso};
                state   <= StRx;
              end else begin
                state <= StGap;
              end
            end else begin
              sclk   <= 1'b1;
              bitCnt <= bitCnt + 7'd1;
            end
          end
        end
        StGap: begin
          // bitCnt counts half-periods here; the rise leaving GAP samples the first RX bit.
          if (halfLast) begin
            if (bitCnt == GapLast) begin
              bitCnt  <= '0;
              sclk    <= 1'b1;
              rxShift <= {rxShift[RX_BITS-2:0], miso};
              state   <= StRx;
            end else begin
              bitCnt <= bitCnt + 7'd1;
            end
          end
        end
        StRx: begin
          if (halfLast) begin
            if (sclk) begin
              sclk <= 1'b0;
            end else if (bitCnt == RxLast) begin
              state <= StHold;
            end else begin
              sclk    <= 1'b1;
              rxShift <= {rxShift[RX_BITS-2:0], miso};
              bitCnt  <= bitCnt + 7'd1;
            end
          end
        end
        StHold: begin
          if (halfLast) begin
            nssAlu <= 1'b1;
            nssMul <= 1'b1;
            nssBas <= 1'b1;
            state  <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b1;
          ready   <= 1'b1;
          addrOut <= addrQ;
`ifdef SPI_CHECKSUM_EN
          res <= rxShift[39:8];
          err <= rxShift[7:0] !=
                 (rxShift[39:32] ^ rxShift[31:24] ^ rxShift[23:16] ^ rxShift[15:8]);
`else
          res <= rxShift;
          err <= 1'b0;
`endif
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_coproc_ctrl.sv
// Scoreboard bench for spi_coproc_ctrl with a mode-0 SPI slave model.
module tb_spi_coproc_ctrl;
  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned TA_CYCLES = 1;
`ifdef SPI_CHECKSUM_EN
  localparam int RxBits = 40;
`else
  localparam int RxBits = 32;
`endif
  localparam int LatN = CLK_DIV * (2 + 2 * (72 + TA_CYCLES + RxBits)) + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        ready;
  logic [2:0]  opcode = '0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [3:0]  addrIn = '0;
  logic [31:0] res;
  logic [3:0]  addrOut;
  logic        done;
  logic        err;
  logic        sclk;
  logic        mosi;
  logic        miso = 1'b0;
  logic        nssAlu;
  logic        nssMul;
  logic        nssBas;

  spi_coproc_ctrl #(.CLK_DIV(CLK_DIV), .TA_CYCLES(TA_CYCLES)) dut (
    .clock(clock), .reset(reset), .req(req), .ready(ready), .opcode(opcode), .opa(opa),
    .opb(opb), .addrIn(addrIn), .res(res), .addrOut(addrOut), .done(done), .err(err),
    .sclk(sclk), .mosi(mosi), .miso(miso), .nssAlu(nssAlu), .nssMul(nssMul), .nssBas(nssBas)
  );

  always #5 clock = ~clock;

  int nChk = 0;
  int nFail = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: captures the 72-bit command, drives {result, checksum} on sclk falls.
  logic        nssAll;
  logic [2:0]  lowMask;
  logic [39:0] slaveResp = '0;
  logic [71:0] capFrame = '0;
  logic [2:0]  touchMask = '0;
  int          riseCnt = 0;
  int          fallCnt = 0;
  logic        sclkPrev = 1'b0;
  logic        nssPrev = 1'b1;
  assign nssAll  = nssAlu & nssMul & nssBas;
  assign lowMask = ~{nssAlu, nssMul, nssBas};

  always @(sclk or nssAlu or nssMul or nssBas) begin
    if (nssPrev && !nssAll) begin
      riseCnt = 0;
      fallCnt = 0;
      capFrame = '0;
      touchMask = '0;
      miso = 1'b0;
    end
    if (!nssAll) touchMask = touchMask | lowMask;
    if (!nssAll && sclk && !sclkPrev) begin
      if (riseCnt < 72) capFrame = {capFrame[70:0], mosi};
      riseCnt++;
    end
    if (!nssAll && !sclk && sclkPrev) begin
      fallCnt++;
      if (fallCnt >= 72 && fallCnt < 112) miso = slaveResp[39 - (fallCnt - 72)];
      else miso = 1'b0;
    end
    sclkPrev = sclk;
    nssPrev  = nssAll;
  end

  typedef struct {
    logic [31:0] res;
    logic [3:0]  addr;
    logic        err;
    logic [71:0] frame;
    logic [2:0]  mask;
    int          acc;
  } exp_t;
  exp_t sbq[$];
  exp_t me;

  always @(negedge clock) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 72'(done), 72'(0));
      end else begin
        me = sbq.pop_front();
        check("latency", 72'(cyc - me.acc), 72'(LatN));
        check("res", 72'(res), 72'(me.res));
        check("addrOut", 72'(addrOut), 72'(me.addr));
        check("err", 72'(err), 72'(me.err));
        check("mosi_frame", capFrame, me.frame);
        check("nss_select", 72'(touchMask), 72'(me.mask));
        check("sclk_rises", 72'(riseCnt), 72'(72 + RxBits));
        check("ready_at_done", 72'(ready), 72'(1));
      end
    end
  end

  // Called at a negedge; issues one request and queues its expected response.
  task automatic doOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] ad, input logic [31:0] word, input logic [7:0] ck);
    exp_t e;
    int n = 0;
    while (!ready && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (!ready) check("ready_timeout", 72'(ready), 72'(1));
    opcode = op;
    opa = a;
    opb = b;
    addrIn = ad;
    req = 1'b1;
    slaveResp = {word, ck};
    e.res = word;
    e.addr = ad;
`ifdef SPI_CHECKSUM_EN
    e.err = (ck != (word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0]));
`else
    e.err = 1'b0;
`endif
    e.frame = {5'b0, op, a, b};
    e.mask = (op[2] == 1'b0) ? 3'b100 : (op[1] == 1'b0) ? 3'b010 : 3'b001;
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clock);
    req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", 72'(sbq.size()), 72'(0));
      sbq.delete();
    end
    repeat (5) @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_ready", 72'(ready), 72'(1));
    check("rst_done", 72'(done), 72'(0));
    check("rst_sclk", 72'(sclk), 72'(0));
    check("rst_mosi", 72'(mosi), 72'(0));
    check("rst_nss", 72'({nssAlu, nssMul, nssBas}), 72'(3'b111));
    check("rst_res", 72'(res), 72'(0));
    check("rst_addrOut", 72'(addrOut), 72'(0));
    check("rst_err", 72'(err), 72'(0));
    reset = 1'b0;
    @(negedge clock);

    // ALU op, plus a request while busy that must be ignored.
    doOp(3'b000, 32'd5, 32'd7, 4'd3, 32'h0000000C, 8'h0C);
    repeat (48) @(negedge clock);
    opcode = 3'b110;
    opa = 32'd9;
    addrIn = 4'd9;
    req = 1'b1;
    @(negedge clock);
    req = 1'b0;
    drain();
    check("res_hold", 72'(res), 72'(32'h0000000C));

    // MUL then BAS back-to-back, then ALU with opcode[1:0] nonzero.
    doOp(3'b101, 32'h00001234, 32'h00000010, 4'd5, 32'hDEADBEEF, 8'h00);
    doOp(3'b110, 32'hCAFEF00D, 32'h80000001, 4'd12, 32'h0F0F5A5A, 8'hAA);
    doOp(3'b011, 32'hFFFFFFFF, 32'h00000000, 4'd15, 32'h80000001, 8'h81);
    drain();

    // Checksum good and bad (err stays 0 without the checksum build).
    doOp(3'b001, 32'h1, 32'h2, 4'd1, 32'h11223344, 8'h44);
    doOp(3'b001, 32'h1, 32'h2, 4'd2, 32'h11223344, 8'h45);
    drain();

    // Reset pulsed during TX bit 40 aborts the transfer.
    doOp(3'b100, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'd7, 32'h12345678, 8'h00);
    repeat (CLK_DIV * (1 + 2 * 40)) @(negedge clock);
    check("rises_at_bit40", 72'(riseCnt), 72'(41));
    reset = 1'b1;
    sbq.delete();
    @(negedge clock);
    check("abort_nss", 72'({nssAlu, nssMul, nssBas}), 72'(3'b111));
    check("abort_sclk", 72'(sclk), 72'(0));
    check("abort_ready", 72'(ready), 72'(1));
    check("abort_done", 72'(done), 72'(0));
    reset = 1'b0;
    @(negedge clock);
    doOp(3'b111, 32'h00000042, 32'h00000024, 4'd10, 32'h76543210, 8'h00);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
